vga_fb_wr_sched: RTL and testbench

Write scheduler for the VGA framebuffer pixel-write port (addr_x/addr_y/color/we). It shares that single port between two independent requesters using round-robin arbitration. It also contains a clear-screen fill engine that sweeps every pixel with one colour. Out-of-range writes are dropped and counted, and the framebuffer's stall signal is honoured.

---
 rtl/vga_fb_wr_sched.sv | 147 ++++++++++++++
 tb/tb_vga_fb_wr_sched.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_wr_sched.sv
// Write scheduler for the VGA framebuffer pixel port: round-robin arbitration of two
// requesters, a clear-screen fill engine and a one-entry stall-aware output register.
module vga_fb_wr_sched #(
    parameter int unsigned X_BITS     = 11,
    parameter int unsigned Y_BITS     = 11,
    parameter int unsigned COLOR_BITS = 2,
    parameter int unsigned HD         = 1280,
    parameter int unsigned VD         = 1024
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic [1:0]              req_valid_i,
    output logic [1:0]              req_ready_o,
    input  logic [2*X_BITS-1:0]     req_x_i,
    input  logic [2*Y_BITS-1:0]     req_y_i,
    input  logic [2*COLOR_BITS-1:0] req_color_i,
    input  logic                    clr_i,
    input  logic [COLOR_BITS-1:0]   clr_color_i,
    output logic                    busy_o,
    output logic                    done_o,
    input  logic                    fb_stall_i,
    output logic [X_BITS-1:0]       addr_x_o,
    output logic [Y_BITS-1:0]       addr_y_o,
    output logic [COLOR_BITS-1:0]   color_o,
    output logic                    we_o,
    output logic [7:0]              err_cnt_o
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(HD - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(VD - 1);

    state_t                state;
    logic                  ov;
    logic [X_BITS-1:0]     ox;
    logic [Y_BITS-1:0]     oy;
    logic [COLOR_BITS-1:0] oc;
    logic                  last_grant;   // 1 when req1 won the most recent accepted transfer
    logic [X_BITS-1:0]     fx;
    logic [Y_BITS-1:0]     fy;
    logic [COLOR_BITS-1:0] fill_color;
    logic [7:0]            err_cnt;

    logic                  slot_free;
    logic [1:0]            grant;
    logic                  accept;
    logic [X_BITS-1:0]     sel_x;
    logic [Y_BITS-1:0]     sel_y;
    logic [COLOR_BITS-1:0] sel_c;
    logic                  sel_in_range;
    logic                  fill_last;

    assign we_o      = ov & ~fb_stall_i;
    assign slot_free = ~ov | we_o;
    assign addr_x_o  = ox;
    assign addr_y_o  = oy;
    assign color_o   = oc;
    assign busy_o    = (state == FILL);
    assign err_cnt_o = err_cnt;
    assign fill_last = (fx == X_LAST) && (fy == Y_LAST);
    assign done_o    = (state == FILL) && slot_free && fill_last;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        grant = req_valid_i;
        if (req_valid_i == 2'b11)
            grant = last_grant ? 2'b01 : 2'b10;

        req_ready_o = 2'b00;
        if (state == IDLE && !clr_i && slot_free)
            req_ready_o = grant;

        accept = |(req_ready_o & req_valid_i);

        sel_x = req_x_i[X_BITS-1:0];
        sel_y = req_y_i[Y_BITS-1:0];
        sel_c = req_color_i[COLOR_BITS-1:0];
        if (req_ready_o[1]) begin
            sel_x = req_x_i[2*X_BITS-1:X_BITS];
            sel_y = req_y_i[2*Y_BITS-1:Y_BITS];
            sel_c = req_color_i[2*COLOR_BITS-1:COLOR_BITS];
        end

        sel_in_range = (32'(sel_x) < HD) && (32'(sel_y) < VD);
    end

    // NOTE: the output data registers are reset too, because the address and colour
    // outputs are driven straight from them and must read 0 out of reset.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state      <= IDLE;
            ov         <= 1'b0;
            ox         <= '0;
            oy         <= '0;
            oc         <= '0;
            last_grant <= 1'b1;
            fx         <= '0;
            fy         <= '0;
            fill_color <= '0;
            err_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments only; a later load in this block overrides the drain.
            if (we_o)
                ov <= 1'b0;

            case (state)
                IDLE: begin
                    if (clr_i) begin
                        state      <= FILL;
                        fx         <= '0;
                        fy         <= '0;
                        fill_color <= clr_color_i;
                    end else if (accept) begin
                        last_grant <= req_ready_o[1];
                        if (sel_in_range) begin
                            ov <= 1'b1;
                            ox <= sel_x;
                            oy <= sel_y;
                            oc <= sel_c;
                        end else if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                FILL: begin
                    if (slot_free) begin
                        ov <= 1'b1;
                        ox <= fx;
                        oy <= fy;
                        oc <= fill_color;
                        if (fill_last) begin
                            state <= IDLE;
                        end else if (fx == X_LAST) begin
                            fx <= '0;
                            fy <= fy + 1'b1;
                        end else begin
                            fx <= fx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fb_wr_sched.sv
// Directed bench: a full-size instance for arbitration/stall/range, a 4x2 instance for fill.
module tb_vga_fb_wr_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    int          errors = 0;
    int          checks = 0;

    // full-size instance (HD=1280, VD=1024)
    logic [1:0]  valid;
    logic [1:0]  ready;
    logic [21:0] rx, ry;
    logic [3:0]  rc;
    logic        clr;
    logic [1:0]  clr_color;
    logic        busy, done, stall, we;
    logic [10:0] ax, ay;
    logic [1:0]  col;
    logic [7:0]  err;

    // small instance (HD=4, VD=2)
    logic [1:0]  s_valid;
    logic [1:0]  s_ready;
    logic [21:0] s_rx, s_ry;
    logic [3:0]  s_rc;
    logic        s_clr;
    logic [1:0]  s_clr_color;
    logic        s_busy, s_done, s_stall, s_we;
    logic [10:0] s_ax, s_ay;
    logic [1:0]  s_col;
    logic [7:0]  s_err;

    always #5 clk = ~clk;

    vga_fb_wr_sched dut (
        .clk_i(clk), .arstn_i(rst_n),
        .req_valid_i(valid), .req_ready_o(ready),
        .req_x_i(rx), .req_y_i(ry), .req_color_i(rc),
        .clr_i(clr), .clr_color_i(clr_color),
        .busy_o(busy), .done_o(done), .fb_stall_i(stall),
        .addr_x_o(ax), .addr_y_o(ay), .color_o(col), .we_o(we),
        .err_cnt_o(err)
    );

    vga_fb_wr_sched #(.HD(4), .VD(2)) dut_small (
        .clk_i(clk), .arstn_i(rst_n),
        .req_valid_i(s_valid), .req_ready_o(s_ready),
        .req_x_i(s_rx), .req_y_i(s_ry), .req_color_i(s_rc),
        .clr_i(s_clr), .clr_color_i(s_clr_color),
        .busy_o(s_busy), .done_o(s_done), .fb_stall_i(s_stall),
        .addr_x_o(s_ax), .addr_y_o(s_ay), .color_o(s_col), .we_o(s_we),
        .err_cnt_o(s_err)
    );

    task automatic clear_inputs();
        valid = 2'b00; rx = '0; ry = '0; rc = '0; clr = 1'b0; clr_color = '0; stall = 1'b0;
        s_valid = 2'b00; s_rx = '0; s_ry = '0; s_rc = '0; s_clr = 1'b0; s_clr_color = '0;
        s_stall = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        #1;
        checks++;
        if ({we, busy, done, ready, ax, ay, col, err} !== '0)
            $display("FAIL reset_big: we=%b busy=%b done=%b ready=%b x=%0d y=%0d c=%0d err=%0d, required all 0",
                     we, busy, done, ready, ax, ay, col, err);
        checks++;
        if ({s_we, s_busy, s_done, s_ready, s_ax, s_ay, s_col, s_err} !== '0)
            $display("FAIL reset_small: we=%b busy=%b done=%b ready=%b, required all 0",
                     s_we, s_busy, s_done, s_ready);
        if ({we, busy, done, ready, ax, ay, col, err} !== '0) errors++;
        if ({s_we, s_busy, s_done, s_ready, s_ax, s_ay, s_col, s_err} !== '0) errors++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        reset_dut();
        @(negedge clk);
        valid = 2'b01; rx[10:0] = 11'd5; ry[10:0] = 11'd7; rc[1:0] = 2'd2;
        #1;
        checks++;
        if (ready !== 2'b01) begin
            errors++; $display("FAIL single_ready: got %b, required 01", ready);
        end
        @(negedge clk);
        valid = 2'b00;
        #1;
        checks++;
        if (we !== 1'b1 || ax !== 11'd5 || ay !== 11'd7 || col !== 2'd2) begin
            errors++;
            $display("FAIL single_write: we=%b x=%0d y=%0d c=%0d, required we=1 x=5 y=7 c=2", we, ax, ay, col);
        end
        @(negedge clk);
        #1;
        checks++;
        if (we !== 1'b0) begin
            errors++; $display("FAIL single_one_pulse: we=%b, required 0", we);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_ready [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [10:0] exp_x     [4] = '{11'd10, 11'd20, 11'd10, 11'd20};
        logic [10:0] exp_y     [4] = '{11'd11, 11'd21, 11'd11, 11'd21};
        logic [1:0]  exp_c     [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
        reset_dut();
        rx = {11'd20, 11'd10}; ry = {11'd21, 11'd11}; rc = {2'd2, 2'd1};
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            valid = (k < 4) ? 2'b11 : 2'b00;
            #1;
            if (k > 0) begin
                checks++;
                if (we !== 1'b1 || ax !== exp_x[k-1] || ay !== exp_y[k-1] || col !== exp_c[k-1]) begin
                    errors++;
                    $display("FAIL contention_write%0d: we=%b x=%0d y=%0d c=%0d, required we=1 x=%0d y=%0d c=%0d",
                             k-1, we, ax, ay, col, exp_x[k-1], exp_y[k-1], exp_c[k-1]);
                end
            end
            if (k < 4) begin
                checks++;
                if (ready !== exp_ready[k]) begin
                    errors++;
                    $display("FAIL contention_grant%0d: ready=%b, required %b", k, ready, exp_ready[k]);
                end
            end
        end
    endtask

    task automatic test_stall();
        reset_dut();
        @(negedge clk);
        valid = 2'b01; rx = {11'd99, 11'd20}; ry = {11'd99, 11'd30}; rc = {2'd3, 2'd1};
        @(negedge clk);
        valid = 2'b11; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (we !== 1'b0 || ax !== 11'd20 || ay !== 11'd30 || col !== 2'd1 || ready !== 2'b00) begin
                errors++;
                $display("FAIL stall_hold%0d: we=%b x=%0d y=%0d c=%0d ready=%b, required we=0 x=20 y=30 c=1 ready=00",
                         k, we, ax, ay, col, ready);
            end
            @(negedge clk);
        end
        valid = 2'b00; stall = 1'b0;
        #1;
        checks++;
        if (we !== 1'b1 || ax !== 11'd20 || ay !== 11'd30 || col !== 2'd1) begin
            errors++;
            $display("FAIL stall_release: we=%b x=%0d y=%0d c=%0d, required we=1 x=20 y=30 c=1", we, ax, ay, col);
        end
        @(negedge clk);
        #1;
        checks++;
        if (we !== 1'b0) begin
            errors++; $display("FAIL stall_no_duplicate: we=%b, required 0", we);
        end
    endtask

    task automatic test_range();
        int we_seen = 0;
        reset_dut();
        @(negedge clk);
        valid = 2'b10; rx = {11'd1280, 11'd0}; ry = '0;
        #1;
        checks++;
        if (ready !== 2'b10) begin
            errors++; $display("FAIL range_accept: ready=%b, required 10", ready);
        end
        @(negedge clk);
        valid = 2'b00;
        #1;
        checks++;
        if (we !== 1'b0 || err !== 8'd1) begin
            errors++; $display("FAIL range_drop: we=%b err=%0d, required we=0 err=1", we, err);
        end
        valid = 2'b10; rx = {11'd0, 11'd0}; ry = {11'd1024, 11'd0};
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (we === 1'b1) we_seen++;
        end
        valid = 2'b00;
        @(negedge clk);
        #1;
        checks++;
        if (err !== 8'd255 || we_seen != 0) begin
            errors++; $display("FAIL range_saturate: err=%0d writes=%0d, required err=255 writes=0", err, we_seen);
        end
        valid = 2'b01; rx = {11'd0, 11'd1279}; ry = {11'd0, 11'd1023}; rc = 4'd3;
        @(negedge clk);
        valid = 2'b00;
        #1;
        checks++;
        if (we !== 1'b1 || ax !== 11'd1279 || ay !== 11'd1023 || col !== 2'd3 || err !== 8'd255) begin
            errors++;
            $display("FAIL range_edge: we=%b x=%0d y=%0d c=%0d err=%0d, required we=1 x=1279 y=1023 c=3 err=255",
                     we, ax, ay, col, err);
        end
    endtask

    task automatic test_fill();
        int idx = 0;
        int dones = 0;
        int busy_cycles = 0;
        logic [10:0] ex, ey;
        reset_dut();
        @(negedge clk);
        s_clr = 1'b1; s_clr_color = 2'd3;
        s_valid = 2'b01; s_rx[10:0] = 11'd1; s_ry[10:0] = 11'd1; s_rc = '0;
        #1;
        checks++;
        if (s_ready !== 2'b00) begin
            errors++; $display("FAIL fill_start_ready: ready=%b, required 00", s_ready);
        end
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            #1;
            if (s_busy === 1'b1) begin
                busy_cycles++;
                checks++;
                if (s_ready !== 2'b00) begin
                    errors++; $display("FAIL fill_ready%0d: ready=%b, required 00", k, s_ready);
                end
            end
            if (s_we === 1'b1) begin
                ex = 11'(idx % 4);
                ey = 11'(idx / 4);
                checks++;
                if (s_ax !== ex || s_ay !== ey || s_col !== 2'd3) begin
                    errors++;
                    $display("FAIL fill_pixel%0d: x=%0d y=%0d c=%0d, required x=%0d y=%0d c=3",
                             idx, s_ax, s_ay, s_col, ex, ey);
                end
                idx++;
            end
            if (s_done === 1'b1) begin
                dones++;
                checks++;
                if (idx != 7) begin
                    errors++; $display("FAIL fill_done_timing: writes_before=%0d, required 7", idx);
                end
                s_clr = 1'b0;
                s_valid = 2'b00;
            end
        end
        checks++;
        if (idx != 8 || dones != 1 || busy_cycles != 8 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_totals: writes=%0d done=%0d busy_cycles=%0d busy=%b, required 8 1 8 0",
                     idx, dones, busy_cycles, s_busy);
        end
    endtask

    task automatic test_reset_mid_fill();
        int wr = 0;
        reset_dut();
        @(negedge clk);
        s_clr = 1'b1; s_clr_color = 2'd2;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            s_clr = 1'b0;
            #1;
            if (s_we === 1'b1) wr++;
            if (wr == 3) break;
        end
        checks++;
        if (wr != 3) begin
            errors++; $display("FAIL mid_fill_progress: writes=%0d, required 3", wr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_busy !== 1'b0 || s_we !== 1'b0 || s_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_fill_reset: busy=%b we=%b done=%b, required 0 0 0", s_busy, s_we, s_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        s_valid = 2'b01; s_rx[10:0] = 11'd2; s_ry[10:0] = 11'd1; s_rc[1:0] = 2'd1;
        #1;
        checks++;
        if (s_ready !== 2'b01) begin
            errors++; $display("FAIL post_reset_ready: ready=%b, required 01", s_ready);
        end
        @(negedge clk);
        s_valid = 2'b00;
        #1;
        checks++;
        if (s_we !== 1'b1 || s_ax !== 11'd2 || s_ay !== 11'd1 || s_col !== 2'd1) begin
            errors++;
            $display("FAIL post_reset_write: we=%b x=%0d y=%0d c=%0d, required we=1 x=2 y=1 c=1",
                     s_we, s_ax, s_ay, s_col);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_range();
        test_fill();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
